// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if
//   Handshake and data bundle between a requester and the multi-cycle
//   shift_sequencer.
//
//   Signals:
//     data_operand   requester -> shifter  value to shift (sampled on start)
//     shamt          requester -> shifter  unsigned shift amount
//     ctrl_sll       requester -> shifter  one-cycle start of logical left
//     ctrl_sra       requester -> shifter  one-cycle start of arithmetic right
//     data_result    shifter -> requester  registered shifted result
//     data_resultRDY shifter -> requester  one-cycle pulse, result valid
//     busy           shifter -> requester  high while shifting
//
//   Modports:
//     master  the requester (ALU control)
//     slave   the shift unit
// ---------------------------------------------------------------------------
interface shift_sequencer_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic [WIDTH-1:0]   data_operand;
  logic [SHAMT_W-1:0] shamt;
  logic               ctrl_sll;
  logic               ctrl_sra;
  logic [WIDTH-1:0]   data_result;
  logic               data_resultRDY;
  logic               busy;

  modport master (
    output data_operand,
    output shamt,
    output ctrl_sll,
    output ctrl_sra,
    input  data_result,
    input  data_resultRDY,
    input  busy
  );

  modport slave (
    input  data_operand,
    input  shamt,
    input  ctrl_sll,
    input  ctrl_sra,
    output data_result,
    output data_resultRDY,
    output busy
  );
endinterface

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Multi-cycle SLL / SRA unit. A single 1-bit shift stage is applied once per
//   clock to a held operand until the requested amount has been consumed.
//
//   Ports:
//     clock   system clock, rising edge
//     resetn  asynchronous active-low reset; discards any in-flight shift
//     io      shift_sequencer_if.slave
//               data_operand / shamt  sampled only on an accepted start
//               ctrl_sll / ctrl_sra   one-cycle start pulses; exactly one
//                                     must be high for the start to count
//               data_result           registered, updates only on DONE entry
//               data_resultRDY        high for the single DONE cycle
//               busy                  high while in SHIFT
//
//   Timing: with the start edge counted as edge 1, data_resultRDY is high in
//   the cycle after edge shamt+1. A start in the DONE cycle is accepted, so
//   operations can run back to back. WIDTH must equal 2**SHAMT_W.
// ---------------------------------------------------------------------------
module shift_sequencer #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                  clock,
  input  logic                  resetn,
  shift_sequencer_if.slave      io
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic {
    OP_SLL = 1'b0,
    OP_SRA = 1'b1
  } op_t;

  localparam logic [SHAMT_W-1:0] COUNT_ZERO = {SHAMT_W{1'b0}};
  localparam logic [SHAMT_W-1:0] COUNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  op_t                op_r;
  logic [WIDTH-1:0]   operand_r;
  logic [SHAMT_W-1:0] count_r;
  logic [WIDTH-1:0]   result_r;
  logic               rdy_r;
  logic               busy_r;

  logic               start_s;
  logic [WIDTH-1:0]   shift_s;

  // Start qualification and the single reused 1-bit shift stage.
  always_comb begin
    start_s = 1'b0;
    shift_s = operand_r;
    // Only IDLE and DONE accept work; both controls high is an invalid request.
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      start_s = io.ctrl_sll ^ io.ctrl_sra;
    end else begin
      start_s = 1'b0;
    end
    if (op_r == OP_SRA) begin
      shift_s = {operand_r[WIDTH-1], operand_r[WIDTH-1:1]};
    end else begin
      shift_s = {operand_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r   <= ST_IDLE;
      op_r      <= OP_SLL;
      operand_r <= {WIDTH{1'b0}};
      count_r   <= COUNT_ZERO;
      result_r  <= {WIDTH{1'b0}};
      rdy_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            operand_r <= io.data_operand;
            op_r      <= io.ctrl_sra ? OP_SRA : OP_SLL;
            count_r   <= io.shamt;
            if (io.shamt == COUNT_ZERO) begin
              // Zero amount bypasses SHIFT; the operand is the result.
              state_r  <= ST_DONE;
              result_r <= io.data_operand;
              rdy_r    <= 1'b1;
              busy_r   <= 1'b0;
            end else begin
              state_r  <= ST_SHIFT;
              rdy_r    <= 1'b0;
              busy_r   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            rdy_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          operand_r <= shift_s;
          count_r   <= count_r - COUNT_ONE;
          if (count_r == COUNT_ONE) begin
            // Last stage: publish the final value only now, so partial
            // shifts never appear on data_result.
            state_r  <= ST_DONE;
            result_r <= shift_s;
            rdy_r    <= 1'b1;
            busy_r   <= 1'b0;
          end else begin
            state_r  <= ST_SHIFT;
            rdy_r    <= 1'b0;
            busy_r   <= 1'b1;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          rdy_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign io.data_result    = result_r;
  assign io.data_resultRDY = rdy_r;
  assign io.busy           = busy_r;

endmodule
